// File: rtl/dot_pipe_arbiter.sv
// dot_pipe_arbiter: round-robin front end for one shared, externally
// instantiated two-multiplier/one-adder dot-product pipeline.
// Picks one eligible requester per cycle and steers its operands to the
// pipeline. The requester ID travels alongside the pipeline latency in a
// tag shift register, so each result comes back tagged with its owner.
// Optional feature macro: DOT_ARB_STATS_EN adds per-requester grant
// counters, read through stat_sel / stat_grants.
module dot_pipe_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned LAT     = 2,
  parameter int unsigned MAX_OUT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [32*N-1:0] req_a1,
  input  logic [32*N-1:0] req_a2,
  input  logic [32*N-1:0] req_b1,
  input  logic [32*N-1:0] req_b2,
  output logic [31:0]     pipe_a1,
  output logic [31:0]     pipe_a2,
  output logic [31:0]     pipe_b1,
  output logic [31:0]     pipe_b2,
  input  logic [31:0]     pipe_c,
  output logic            resp_valid,
  output logic [IDW-1:0]  resp_id,
  output logic [31:0]     resp_data,
  output logic            busy
`ifdef DOT_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]  stat_sel,
  output logic [31:0]     stat_grants
`endif
);

  localparam logic [2:0]     LP_MAX_OUT  = 3'(MAX_OUT);
  localparam logic [IDW-1:0] LP_LAST_RST = IDW'(N - 1);

  logic [N-1:0]   w_elig;
  logic [N-1:0]   w_inc;
  logic [N-1:0]   w_dec;
  logic           w_grant_any;
  logic [IDW-1:0] w_grant_id;
  logic [IDW-1:0] w_idx;

  logic [IDW-1:0] r_last_grant;
  logic [2:0]     r_out_cnt [N];
  logic [LAT-1:0] r_tag_v;
  logic [IDW-1:0] r_tag_id  [LAT];

  // Eligibility: operands present, below the in-flight cap, not held, not in reset
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_elig[i] = req_valid[i] & (r_out_cnt[i] < LP_MAX_OUT) & ~hold & ~reset;
    end
  end

  // Round-robin search starting just after the last granted requester, wrapping
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = IDW'((32'(r_last_grant) + k) % N);
      if (!w_grant_any && w_elig[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_idx;
      end
    end
  end

  // One-hot grant and per-requester counter up/down strobes
  always_comb begin
    req_ready = '0;
    w_inc     = '0;
    w_dec     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_ready[i] = w_grant_any && (w_grant_id == IDW'(i));
      w_inc[i]     = req_ready[i];
      w_dec[i]     = resp_valid && (resp_id == IDW'(i));
    end
  end

  // Operand mux: granted requester's operands, zero when nothing is granted
  always_comb begin
    pipe_a1 = '0;
    pipe_a2 = '0;
    pipe_b1 = '0;
    pipe_b2 = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        pipe_a1 = req_a1[32*i +: 32];
        pipe_a2 = req_a2[32*i +: 32];
        pipe_b1 = req_b1[32*i +: 32];
        pipe_b2 = req_b2[32*i +: 32];
      end
    end
  end

  // Round-robin pointer moves only on a granting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= LP_LAST_RST;
    end else if (w_grant_any) begin
      r_last_grant <= w_grant_id;
    end
  end

  // Tag pipeline {v,id} shadowing the external pipeline latency
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int unsigned l = 0; l < LAT; l++) begin
        r_tag_id[l] <= '0;
      end
    end else begin
      r_tag_v[0]  <= w_grant_any;
      r_tag_id[0] <= w_grant_id;
      for (int unsigned l = 1; l < LAT; l++) begin
        r_tag_v[l]  <= r_tag_v[l-1];
        r_tag_id[l] <= r_tag_id[l-1];
      end
    end
  end

  // In-flight counters: +1 on grant, -1 on matching response, both cancel
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_out_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        case ({w_inc[i], w_dec[i]})
          2'b10:   r_out_cnt[i] <= r_out_cnt[i] + 3'd1;
          2'b01:   r_out_cnt[i] <= r_out_cnt[i] - 3'd1;
          default: r_out_cnt[i] <= r_out_cnt[i];
        endcase
      end
    end
  end

  // The pipeline is not reset; the tag valid bit is what qualifies its output
  assign resp_valid = r_tag_v[LAT-1];
  assign resp_id    = r_tag_id[LAT-1];
  assign resp_data  = pipe_c;
  assign busy       = |r_tag_v;

`ifdef DOT_ARB_STATS_EN
  logic [31:0] r_stat_cnt [N];

  // Per-requester grant counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_stat_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (w_inc[i]) begin
          r_stat_cnt[i] <= r_stat_cnt[i] + 32'd1;
        end
      end
    end
  end

  // Combinational counter readback; selects beyond N read zero
  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (stat_sel == IDW'(i)) begin
        stat_grants = r_stat_cnt[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_dot_pipe_arbiter.sv
// Directed bench for dot_pipe_arbiter. A two-stage behavioural dot-product
// pipeline (C = A1*B1 + A2*B2) stands in for the external shared unit.
// MAX_OUT is set to 2 so that, with LAT=2, the in-flight cap actually
// produces a stall pattern (grant, grant, stall) for a lone requester.
module tb_dot_pipe_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a1, req_a2, req_b1, req_b2;
  logic [31:0]     pipe_a1, pipe_a2, pipe_b1, pipe_b2;
  logic [31:0]     pipe_c;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic [31:0]     resp_data;
  logic            busy;
`ifdef DOT_ARB_STATS_EN
  logic [IDW-1:0]  stat_sel;
  logic [31:0]     stat_grants;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pl_s1;

  always #5 clk = ~clk;

  dot_pipe_arbiter #(.N(4), .IDW(2), .LAT(2), .MAX_OUT(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a1     (req_a1),
    .req_a2     (req_a2),
    .req_b1     (req_b1),
    .req_b2     (req_b2),
    .pipe_a1    (pipe_a1),
    .pipe_a2    (pipe_a2),
    .pipe_b1    (pipe_b1),
    .pipe_b2    (pipe_b2),
    .pipe_c     (pipe_c),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
`ifdef DOT_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_grants(stat_grants)
`endif
  );

  // External pipeline model: captures on the handshake edge, result two cycles later
  always @(posedge clk) begin
    pl_s1  <= pipe_a1 * pipe_b1 + pipe_a2 * pipe_b2;
    pipe_c <= pl_s1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [31:0] a2, input logic [31:0] b2);
    req_a1[32*i +: 32] = a1;
    req_b1[32*i +: 32] = b1;
    req_a2[32*i +: 32] = a2;
    req_b2[32*i +: 32] = b2;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    hold      = 1'b0;
    tick();
    reset     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hold = 1'b0; req_valid = '0;
    req_a1 = '0; req_a2 = '0; req_b1 = '0; req_b2 = '0;
`ifdef DOT_ARB_STATS_EN
    stat_sel = '0;
`endif
    tick();
    tick();

    // Reset state: requests are ignored while reset is high
    req_valid = 4'hF;
    set_ops(0, 32'd9, 32'd9, 32'd9, 32'd9);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_pipe_a1", pipe_a1, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    req_valid = '0;
    reset = 1'b0;
    tick();

    // Single request from requester 0: 3*4 + 5*6 = 42
    set_ops(0, 32'd3, 32'd4, 32'd5, 32'd6);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_pipe_a1", pipe_a1, 32'd3);
    chk("t1_pipe_b2", pipe_b2, 32'd6);
    tick();
    req_valid = '0;
    #1;
    chk("t1_busy_t1", 32'(busy), 32'h1);
    chk("t1_rv_t1", 32'(resp_valid), 32'h0);
    tick();
    chk("t1_rv_t2", 32'(resp_valid), 32'h1);
    chk("t1_rid_t2", 32'(resp_id), 32'h0);
    chk("t1_rdata_t2", resp_data, 32'd42);
    chk("t1_busy_t2", 32'(busy), 32'h1);
    tick();
    chk("t1_rv_t3", 32'(resp_valid), 32'h0);
    chk("t1_busy_t3", 32'(busy), 32'h0);

    // Round robin: all four valid, result for id i = (i+1)*10 + 2*i = 12i+10
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 32'(i + 1), 32'd10, 32'd2, 32'(i));
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      else       chk("rr_ready_idle", 32'(req_ready), 32'h0);
      if (c >= 2) begin
        chk("rr_rv", 32'(resp_valid), 32'h1);
        chk("rr_rid", 32'(resp_id), 32'((c - 2) % 4));
        chk("rr_rdata", resp_data, 32'(12 * ((c - 2) % 4) + 10));
      end else begin
        chk("rr_rv_early", 32'(resp_valid), 32'h0);
      end
      tick();
    end
    chk("rr_drained", 32'(resp_valid), 32'h0);

    // In-flight cap (2) for a lone requester 1: grant, grant, stall, repeating
    req_valid = 4'b0010;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk("cap_ready", 32'(req_ready), (c % 3 != 2) ? 32'h2 : 32'h0);
      if (c >= 2) chk("cap_rv", 32'(resp_valid), ((c - 2) % 3 != 2) ? 32'h1 : 32'h0);
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("cap_drained_busy", 32'(busy), 32'h0);

    // Hold: in-flight result from requester 2 still returns, 7*7+1*1 = 50
    set_ops(2, 32'd7, 32'd7, 32'd1, 32'd1);
    req_valid = 4'b0100;
    #1;
    chk("hold_pre_ready", 32'(req_ready), 32'h4);
    tick();
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_ready", 32'(req_ready), 32'h0);
      chk("hold_pipe_a1", pipe_a1, 32'h0);
      chk("hold_pipe_b1", pipe_b1, 32'h0);
      if (c == 1) begin
        chk("hold_rv", 32'(resp_valid), 32'h1);
        chk("hold_rid", 32'(resp_id), 32'h2);
        chk("hold_rdata", resp_data, 32'd50);
      end else begin
        chk("hold_rv_idle", 32'(resp_valid), 32'h0);
      end
      tick();
    end
    hold = 1'b0;
    #1;
    chk("hold_release_ready", 32'(req_ready), 32'h4);
    chk("hold_release_a1", pipe_a1, 32'd7);
    tick();
    req_valid = '0;
    tick();
    chk("hold_after_rv", 32'(resp_valid), 32'h1);
    chk("hold_after_rdata", resp_data, 32'd50);
    tick();

    // Reset one cycle after a grant: result discarded, counters cleared
    set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2);
    req_valid = 4'b0001;
    #1;
    chk("rm_grant", 32'(req_ready), 32'h1);
    tick();
    reset = 1'b1;
    #1;
    chk("rm_ready_in_rst", 32'(req_ready), 32'h0);
    tick();
    reset = 1'b0;
    req_valid = '0;
    #1;
    chk("rm_rv_a", 32'(resp_valid), 32'h0);
    chk("rm_busy_a", 32'(busy), 32'h0);
    tick();
    chk("rm_rv_b", 32'(resp_valid), 32'h0);
    // Two back-to-back grants only succeed if the counter was cleared
    req_valid = 4'b0001;
    #1;
    chk("rm_new_grant0", 32'(req_ready), 32'h1);
    tick();
    chk("rm_new_grant1", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("rm_new_rv0", 32'(resp_valid), 32'h1);
    chk("rm_new_rid0", 32'(resp_id), 32'h0);
    chk("rm_new_rdata0", resp_data, 32'h0000_0005);
    tick();
    chk("rm_new_rv1", 32'(resp_valid), 32'h1);
    chk("rm_new_rdata1", resp_data, 32'h0000_0005);
    tick();
    chk("rm_new_idle", 32'(resp_valid), 32'h0);

`ifdef DOT_ARB_STATS_EN
    // Ten round-robin grants over four requesters: 3,3,2,2
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) tick();
    req_valid = '0;
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      stat_sel = IDW'(i);
      #1;
      chk("stat_grants", stat_grants, (i < 2) ? 32'd3 : 32'd2);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
